// File: rtl/avalon_mem_burst_responder.sv
// Avalon-MM burst responder backed by an internal RAM.
// Terminates the FIU end of an avalon_mem_if and services burst reads and
// writes exactly as a physical local-memory bank would.
// Optional build macro: AVALON_MEM_RESPONDER_STALL_EN adds pseudo-random
// waitrequest stalls (16-bit LFSR) in IDLE and WR_BURST.
module avalon_mem_burst_responder #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_CNT_WIDTH = 4,
  parameter int BANK_NUMBER     = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [BURST_CNT_WIDTH-1:0] burstcount,
  input  logic                       read,
  input  logic                       write,
  input  logic [DATA_WIDTH-1:0]      writedata,
  input  logic [DATA_WIDTH/8-1:0]    byteenable,
  output logic                       waitrequest,
  output logic [DATA_WIDTH-1:0]      readdata,
  output logic                       readdatavalid,
  output logic [7:0]                 bank_number,
  output logic                       proto_err
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << ADDR_WIDTH;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_BURST = 2'd2;

  localparam logic [BURST_CNT_WIDTH-1:0] BC_ZERO = BURST_CNT_WIDTH'(0);
  localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE  = BURST_CNT_WIDTH'(1);

  logic [1:0]                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]      base_q, base_d;
  logic [BURST_CNT_WIDTH-1:0] beat_q, beat_d;     // beat index k within the burst
  logic [BURST_CNT_WIDTH-1:0] count_q, count_d;   // write: beats left; read: total beats
  logic                       waitrequest_q, waitrequest_d;
  logic                       proto_err_q, proto_err_d;
  logic                       rd_pend_q, rd_pend_d; // RAM read issued last cycle
  logic                       readdatavalid_q, readdatavalid_d;
  logic [DATA_WIDTH-1:0]      readdata_q, readdata_d;
  logic [DATA_WIDTH-1:0]      ram_rdata_q;

  logic                       accept_s;
  logic                       stall_s;
  logic [ADDR_WIDTH-1:0]      beat_addr_s;
  logic                       mem_we_s;
  logic                       mem_re_s;
  logic [ADDR_WIDTH-1:0]      mem_waddr_s;
  logic [ADDR_WIDTH-1:0]      mem_raddr_s;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];

  assign accept_s    = (read || write) && !waitrequest_q;
  assign beat_addr_s = base_q + ADDR_WIDTH'(beat_q);  // wraps modulo 2^ADDR_WIDTH
  assign bank_number = 8'(BANK_NUMBER);

`ifdef AVALON_MEM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,15,13,4, free-running every cycle
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
  end

  // LFSR state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Stall decision uses the LFSR value that will be current next cycle
  assign stall_s = (lfsr_d[1:0] == 2'b00);
`else
  assign stall_s = 1'b0;
`endif

  // Next-state, RAM port control and protocol-error detection
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    beat_d      = beat_q;
    count_d     = count_q;
    proto_err_d = proto_err_q;
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    mem_waddr_s = address;
    mem_raddr_s = beat_addr_s;

    case (state_q)
      IDLE: begin
        if (accept_s && write) begin
          // write wins over a simultaneous read; first beat goes to address
          mem_we_s    = 1'b1;
          mem_waddr_s = address;
          base_d      = address;
          beat_d      = BC_ONE;
          if (read || (burstcount == BC_ZERO)) begin
            proto_err_d = 1'b1;
          end else begin
            proto_err_d = proto_err_q;
          end
          if (burstcount > BC_ONE) begin
            count_d = burstcount - BC_ONE;
            state_d = WR_BURST;
          end else begin
            count_d = count_q;
            state_d = IDLE;
          end
        end else if (accept_s) begin
          // read command: zero-length burst is treated as one beat
          base_d = address;
          beat_d = BC_ZERO;
          if (burstcount == BC_ZERO) begin
            count_d     = BC_ONE;
            proto_err_d = 1'b1;
          end else begin
            count_d     = burstcount;
            proto_err_d = proto_err_q;
          end
          state_d = RD_BURST;
        end else begin
          state_d = IDLE;
        end
      end

      WR_BURST: begin
        if (read) begin
          proto_err_d = 1'b1;
        end else begin
          proto_err_d = proto_err_q;
        end
        if (write && !waitrequest_q) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = beat_addr_s;
          beat_d      = beat_q + BC_ONE;
          count_d     = count_q - BC_ONE;
          if (count_q == BC_ONE) begin
            state_d = IDLE;
          end else begin
            state_d = WR_BURST;
          end
        end else begin
          state_d = WR_BURST;
        end
      end

      RD_BURST: begin
        // one RAM read per cycle, never stalled once the burst is issued
        mem_re_s    = 1'b1;
        mem_raddr_s = beat_addr_s;
        beat_d      = beat_q + BC_ONE;
        if (beat_q == (count_q - BC_ONE)) begin
          state_d = IDLE;
        end else begin
          state_d = RD_BURST;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered output staging: waitrequest tracks the next state
  always_comb begin
    waitrequest_d   = (state_d == RD_BURST) || stall_s;
    rd_pend_d       = mem_re_s;
    readdatavalid_d = rd_pend_q;
    if (rd_pend_q) begin
      readdata_d = ram_rdata_q;
    end else begin
      readdata_d = readdata_q;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      base_q          <= {ADDR_WIDTH{1'b0}};
      beat_q          <= BC_ZERO;
      count_q         <= BC_ZERO;
      waitrequest_q   <= 1'b1;
      proto_err_q     <= 1'b0;
      rd_pend_q       <= 1'b0;
      readdatavalid_q <= 1'b0;
      readdata_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      beat_q          <= beat_d;
      count_q         <= count_d;
      waitrequest_q   <= waitrequest_d;
      proto_err_q     <= proto_err_d;
      rd_pend_q       <= rd_pend_d;
      readdatavalid_q <= readdatavalid_d;
      readdata_q      <= readdata_d;
    end
  end

  // RAM array: byte-enabled write port, registered read port, never cleared
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (mem_we_s && byteenable[b]) begin
        mem[mem_waddr_s][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
    if (mem_re_s) begin
      ram_rdata_q <= mem[mem_raddr_s];
    end
  end

  assign waitrequest   = waitrequest_q;
  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_avalon_mem_burst_responder.sv
// Directed self-checking bench for avalon_mem_burst_responder.
// Build with AVALON_MEM_RESPONDER_STALL_EN defined to add the stall scenario.
module tb_avalon_mem_burst_responder;

  logic        clk;
  logic        reset_n;
  logic [9:0]  address;
  logic [3:0]  burstcount;
  logic        read;
  logic        write;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic        waitrequest;
  logic [63:0] readdata;
  logic        readdatavalid;
  logic [7:0]  bank_number;
  logic        proto_err;

  int          n_vec;
  int          n_err;
  int          cyc;
  logic [63:0] rq_data[$];
  int          rq_cyc[$];
  logic [63:0] exp_data[$];
  int          exp_cyc[$];

  avalon_mem_burst_responder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .burstcount    (burstcount),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .bank_number   (bank_number),
    .proto_err     (proto_err)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time-stamp read beats
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every readdatavalid beat away from the active edge
  always @(negedge clk) begin
    if (readdatavalid) begin
      rq_data.push_back(readdata);
      rq_cyc.push_back(cyc);
    end
  end

`ifdef AVALON_MEM_RESPONDER_STALL_EN
  logic [15:0] m_lfsr;
  // Reference LFSR for predicting stall cycles
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
  end
`endif

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rd();
    rq_data.delete();
    rq_cyc.delete();
    exp_data.delete();
    exp_cyc.delete();
  endtask

  // Compare captured read beats against the expected data/cycle lists
  task automatic check_beats(input string tag);
    check_eq({tag, "_count"}, 64'(rq_data.size()), 64'(exp_data.size()));
    if (rq_data.size() == exp_data.size()) begin
      for (int i = 0; i < exp_data.size(); i++) begin
        check_eq({tag, "_data"}, rq_data[i], exp_data[i]);
        check_eq({tag, "_cyc"}, 64'(rq_cyc[i]), 64'(exp_cyc[i]));
      end
    end
  endtask

  // Present one write beat and hold it until accepted
  task automatic wr_beat(input logic [9:0] a, input logic [3:0] bc,
                         input logic [63:0] d, input logic [7:0] be);
    int n;
    @(negedge clk);
    write = 1'b1; address = a; burstcount = bc; writedata = d; byteenable = be;
    n = 0;
    while (waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("wr_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  // Issue a read command; t returns the cycle stamp of the accepting edge
  task automatic do_read(input logic [9:0] a, input logic [3:0] bc, output int t);
    int n;
    @(negedge clk);
    read = 1'b1; address = a; burstcount = bc;
    n = 0;
    while (waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("rd_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 read = 1'b0;
    t = cyc;
  endtask

  initial begin
    int t1;
    int t2;
    n_vec = 0; n_err = 0; cyc = 0;
    reset_n = 1'b0; read = 1'b0; write = 1'b0;
    address = 10'd0; burstcount = 4'd0; writedata = 64'd0; byteenable = 8'h00;

    // ---- reset release ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_waitreq", 64'(waitrequest), 64'd1);
    check_eq("rst_rdv", 64'(readdatavalid), 64'd0);
    check_eq("rst_readdata", readdata, 64'd0);
    check_eq("rst_proto_err", 64'(proto_err), 64'd0);
    check_eq("bank_number", 64'(bank_number), 64'd0);
    reset_n = 1'b1;
    #1 check_eq("rel_waitreq_hold", 64'(waitrequest), 64'd1);
    @(posedge clk);
    #1 check_eq("rel_waitreq_drop", 64'(waitrequest), 64'd0);
    check_eq("rel_rdv", 64'(readdatavalid), 64'd0);

    // ---- single write / read ----
    wr_beat(10'h005, 4'd1, 64'hDEADBEEF_01234567, 8'hFF);
    clear_rd();
    do_read(10'h005, 4'd1, t1);
    exp_data.push_back(64'hDEADBEEF_01234567); exp_cyc.push_back(t1 + 2);
    wait_cyc(6);
    check_beats("single");

    // ---- burst with gap, byte enables and address wrap ----
    wr_beat(10'h000, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr_beat(10'h3FE, 4'd4, 64'd1, 8'hFF);
    wr_beat(10'h000, 4'd0, 64'd2, 8'hFF);   // address/burstcount ignored mid-burst
    @(posedge clk);                          // one idle gap cycle
    wr_beat(10'h000, 4'd0, 64'd3, 8'h0F);
    wr_beat(10'h000, 4'd0, 64'd4, 8'hFF);
    check_eq("burst_no_proto_err", 64'(proto_err), 64'd0);
    clear_rd();
    do_read(10'h3FE, 4'd4, t1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("burst_rd_waitreq_hi", 64'(waitrequest), 64'd1);
    end
`ifndef AVALON_MEM_RESPONDER_STALL_EN
    @(negedge clk);
    check_eq("burst_rd_waitreq_lo", 64'(waitrequest), 64'd0);
`endif
    exp_data = '{64'd1, 64'd2, 64'hFFFFFFFF_00000003, 64'd4};
    for (int i = 0; i < 4; i++) exp_cyc.push_back(t1 + 2 + i);
    wait_cyc(6);
    check_beats("burst");

    // ---- protocol error: read and write together ----
    clear_rd();
    @(negedge clk);
    read = 1'b1; write = 1'b1; address = 10'h007; burstcount = 4'd1;
    writedata = 64'h7777_0000_1111_7777; byteenable = 8'hFF;
    t1 = 0;
    while (waitrequest && t1 < 200) begin
      @(negedge clk);
      t1++;
    end
    @(posedge clk);
    #1 begin read = 1'b0; write = 1'b0; end
    wait_cyc(5);
    check_eq("rw_no_rdv", 64'(rq_data.size()), 64'd0);
    check_eq("rw_proto_err", 64'(proto_err), 64'd1);
    do_read(10'h007, 4'd1, t1);
    exp_data.push_back(64'h7777_0000_1111_7777); exp_cyc.push_back(t1 + 2);
    wait_cyc(5);
    check_beats("rw_write_done");

    // ---- protocol error: zero burstcount write is a single beat ----
    wr_beat(10'h002, 4'd0, 64'h2222_3333_4444_5555, 8'hFF);
    wr_beat(10'h003, 4'd1, 64'h0000_0000_0000_0033, 8'hFF);  // lands in IDLE, not mid-burst
    check_eq("bc0_proto_err", 64'(proto_err), 64'd1);

    // ---- back-to-back read bursts of 2 and 3 ----
    clear_rd();
    do_read(10'h3FE, 4'd2, t1);
    do_read(10'h000, 4'd3, t2);
    check_eq("b2b_accept_cycle", 64'(t2), 64'(t1 + 3));
    exp_data = '{64'd1, 64'd2, 64'hFFFFFFFF_00000003, 64'd4, 64'h2222_3333_4444_5555};
    exp_cyc.push_back(t1 + 2); exp_cyc.push_back(t1 + 3);
    for (int i = 0; i < 3; i++) exp_cyc.push_back(t2 + 2 + i);
    wait_cyc(8);
    check_beats("b2b");
    check_eq("b2b_proto_err_sticky", 64'(proto_err), 64'd1);

`ifdef AVALON_MEM_RESPONDER_STALL_EN
    // ---- stalled 8-beat write, write held high ----
    begin
      int acc;
      int n;
      logic acc_now;
      @(negedge clk);
      write = 1'b1; address = 10'h100; burstcount = 4'd8; byteenable = 8'hFF;
      writedata = 64'hA0;
      acc = 0; n = 0;
      while (acc < 8 && n < 200) begin
        check_eq("stall_waitreq", 64'(waitrequest), 64'(m_lfsr[1:0] == 2'b00));
        acc_now = !waitrequest;
        @(posedge clk);
        #1 if (acc_now) begin
          acc++;
          writedata = 64'hA0 + 64'(acc);
        end
        @(negedge clk);
        n++;
      end
      write = 1'b0;
      check_eq("stall_accepted", 64'(acc), 64'd8);
      clear_rd();
      do_read(10'h100, 4'd8, t1);
      for (int i = 0; i < 8; i++) begin
        exp_data.push_back(64'hA0 + 64'(i));
        exp_cyc.push_back(t1 + 2 + i);
      end
      wait_cyc(12);
      check_beats("stall_rd");
    end
`endif

    // ---- reset mid read burst: in-flight beats dropped ----
    clear_rd();
    do_read(10'h3FE, 4'd4, t1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_rdv", 64'(readdatavalid), 64'd0);
    check_eq("mid_rst_waitreq", 64'(waitrequest), 64'd1);
    check_eq("mid_rst_proto_err", 64'(proto_err), 64'd0);
    rq_data.delete();
    rq_cyc.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check_eq("mid_rst_waitreq_drop", 64'(waitrequest), 64'd0);
    wait_cyc(6);
    check_eq("mid_rst_dropped", 64'(rq_data.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
